// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the sequential ALU. This package holds
//             the operation codes, the FSM state encodings, and the flag
//             helper functions used by seq_alu.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Operation codes presented on alu_op
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_REM = 3'd7;

    // Controller state encodings
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_ONE  = 3'd1;
    localparam state_t ST_PREP = 3'd2;
    localparam state_t ST_ITER = 3'd3;
    localparam state_t ST_FIX  = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    // Returns 1 for the ops that can finish in a single cycle
    function automatic logic is_single_cycle(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    // Signed overflow for a+b: both operands have the same sign, and the
    // result has the opposite sign
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow for a-b: the operands have different signs, and the
    // result sign differs from the sign of a
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_if
//  Purpose  : Request/response bundle for seq_alu.
//             Request side : in_valid, in_ready, a, b, alu_op
//             Response side: out_valid, out_ready, result, V, C, Z, S, dz
//             master = the producer/consumer pipeline stage
//             slave  = the ALU
//  Revision : 1.0  initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             V;
    logic             C;
    logic             Z;
    logic             S;
    logic             dz;

    modport master (
        output in_valid, a, b, alu_op, out_ready,
        input  in_ready, out_valid, result, V, C, Z, S, dz
    );

    modport slave (
        input  in_valid, a, b, alu_op, out_ready,
        output in_ready, out_valid, result, V, C, Z, S, dz
    );
endinterface
`default_nettype wire

// File: rtl/seq_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : seq_muldiv_unit
//  Purpose  : Unsigned iterative engine. It runs one bit per cycle for
//             WIDTH cycles.
//             - Multiply: shift-add. hi accumulates, and lo holds the
//               multiplier and then the low product bits.
//             - Divide  : restoring division. hi holds the partial
//               remainder, and lo holds the dividend and then the quotient.
//  Ports    : clk, rst_n        clock, async active-low reset
//             start, op         load operands (op==OP_MUL selects multiply)
//             opa, opb          unsigned magnitudes (opa = multiplicand /
//                               dividend, opb = multiplier / divisor)
//             done              high during the final iteration cycle
//             prod, quot, rem   results, valid the cycle after done
//  Revision : 1.0  initial release
// ============================================================================
module seq_muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    input  wire logic [2:0]         op,
    input  wire logic [WIDTH-1:0]   opa,
    input  wire logic [WIDTH-1:0]   opb,
    output logic                    done,
    output logic [2*WIDTH-1:0]      prod,
    output logic [WIDTH-1:0]        quot,
    output logic [WIDTH-1:0]        rem
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_div;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // Done is combinational, so the controller can leave ITER on the same
    // edge that retires the last bit.
    assign done = r_busy && (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
        w_shift  = {r_hi, r_lo[WIDTH-1]};
        w_trial  = w_shift - {1'b0, r_m};
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_div) begin
            // When the trial subtraction is non-negative, keep it and
            // shift in a quotient 1. Otherwise restore the shifted value.
            if (!w_trial[WIDTH]) begin
                w_hi_nxt = w_trial[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift the (carry, accumulator, multiplier) chain right by one
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_m    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_div  <= 1'b0;
        end else if (start) begin
            r_hi   <= '0;
            r_lo   <= (op == OP_MUL) ? opb : opa;
            r_m    <= (op == OP_MUL) ? opa : opb;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_div  <= (op != OP_MUL);
        end else if (r_busy) begin
            r_hi   <= w_hi_nxt;
            r_lo   <= w_lo_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign prod = {r_hi, r_lo};
    assign quot = r_lo;
    assign rem  = r_hi;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Registered ALU with valid/ready handshakes on both sides.
//             - ADD/SUB/logic ops take 1 cycle when FAST_LOGIC=1.
//             - MUL/DIV/REM, and every op when FAST_LOGIC=0, run through
//               PREP / ITER(WIDTH cycles) / FIX.
//  Ports    : clk     rising-edge clock
//             rst_n   asynchronous active-low reset
//             bus     seq_alu_if.slave
//                     (in_valid/in_ready/a/b/alu_op,
//                      out_valid/out_ready/result/V/C/Z/S/dz)
//  Revision : 1.0  initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FAST_LOGIC = 1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    seq_alu_if.slave   bus
);
    localparam logic [WIDTH-1:0] c_min  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ones = {WIDTH{1'b1}};

    state_t           r_state;
    state_t           w_next;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_v, r_c, r_z, r_s, r_dz;

    logic             w_accept;
    logic             w_fast_op;
    logic             w_start;
    logic             w_load;
    logic             w_out_valid;

    logic             w_eng_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_neg_q;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH:0]   w_hi_ext;
    logic [WIDTH-1:0] w_quot_s;
    logic [WIDTH-1:0] w_rem_s;

    logic [WIDTH-1:0] w_res;
    logic             w_v, w_c, w_dz;

    assign w_accept  = bus.in_valid && r_in_ready && (r_state == ST_IDLE);
    assign w_fast_op = (FAST_LOGIC != 0) && is_single_cycle(bus.alu_op);

    // ------------------------------------------------------------------
    // State register. in_ready is registered, so it stays low during
    // reset and rises on the first edge after release.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == ST_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_fast_op ? ST_ONE : ST_PREP;
            ST_ONE:  w_next = ST_DONE;
            ST_PREP: w_next = ST_ITER;
            ST_ITER: if (w_eng_done) w_next = ST_FIX;
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_start     = (r_state == ST_PREP);
        w_load      = (r_state == ST_ONE) || (r_state == ST_FIX);
        w_out_valid = (r_state == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Magnitudes feed the engine. The sign is taken back from the
    // captured operands in FIX. |MIN| is exactly representable as an
    // unsigned WIDTH-bit value.
    // ------------------------------------------------------------------
    assign w_abs_a = r_a[WIDTH-1] ? (~r_a + 1'b1) : r_a;
    assign w_abs_b = r_b[WIDTH-1] ? (~r_b + 1'b1) : r_b;

    seq_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .op    (r_op),
        .opa   (w_abs_a),
        .opb   (w_abs_b),
        .done  (w_eng_done),
        .prod  (w_prod),
        .quot  (w_quot),
        .rem   (w_rem)
    );

    assign w_neg_q  = r_a[WIDTH-1] ^ r_b[WIDTH-1];
    assign w_prod_s = w_neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quot_s = w_neg_q ? (~w_quot + 1'b1) : w_quot;
    assign w_rem_s  = r_a[WIDTH-1] ? (~w_rem + 1'b1) : w_rem;
    // The product fits in WIDTH bits iff its top WIDTH+1 bits are all equal
    assign w_hi_ext = w_prod_s[2*WIDTH-1:WIDTH-1];

    // Result and V/C/dz for the captured op. Engine outputs are only
    // meaningful in FIX, which is the only time they are loaded.
    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        w_c   = 1'b0;
        w_dz  = 1'b0;
        case (r_op)
            OP_ADD: begin
                {w_c, w_res} = {1'b0, r_a} + {1'b0, r_b};
                w_v = add_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_res[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = r_a - r_b;
                w_c   = (r_a < r_b);
                w_v   = sub_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_res[WIDTH-1]);
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_MUL: begin
                w_res = w_prod_s[WIDTH-1:0];
                w_v   = !((&w_hi_ext) || !(|w_hi_ext));
            end
            OP_DIV: begin
                if (r_b == '0) begin
                    w_res = c_ones;
                    w_dz  = 1'b1;
                end else begin
                    // MIN / -1 negates 2^(WIDTH-1) back to MIN, so only V
                    // needs special handling.
                    w_res = w_quot_s;
                    w_v   = (r_a == c_min) && (r_b == c_ones);
                end
            end
            OP_REM: begin
                if (r_b == '0) begin
                    w_res = r_a;
                    w_dz  = 1'b1;
                end else begin
                    w_res = w_rem_s;
                end
            end
            default: w_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture and the result/flag registers. These registers
    // hold their values while waiting for out_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_result <= '0;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_s      <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= bus.a;
                r_b  <= bus.b;
                r_op <= bus.alu_op;
            end
            if (w_load) begin
                r_result <= w_res;
                r_v      <= w_v;
                r_c      <= w_c;
                r_z      <= (w_res == '0);
                r_s      <= w_res[WIDTH-1];
                r_dz     <= w_dz;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.V         = r_v;
    assign bus.C         = r_c;
    assign bus.Z         = r_z;
    assign bus.S         = r_s;
    assign bus.dz        = r_dz;

endmodule
`default_nettype wire
